clk_div_prog: RTL and testbench

- Programmable synchronous clock divider / enable generator. Parametrised successor to the fixed divide-by-16 flip-flop chain.
- All logic runs on one clock; no derived clocks drive flops.
- Produces a divided square wave `clk_out` (used as data, not as a clock) and a one-cycle `tick` enable at each period start, for downstream counters and LED/beeper timers.
- Divide ratio is runtime-loadable. Changes take effect glitch-free, only at a period boundary.

---
 rtl/clk_div_prog.sv | 184 ++++++++++++++++++
 tb/tb_clk_div_prog.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Programmable synchronous clock divider / enable generator. Everything runs
// on clk. clk_out is a registered data-level waveform, not a clock, and must
// never be used to clock flops.
//
// The active ratio N sets the period. A running period is high for
// ceil(N/2) cycles and low for floor(N/2) cycles. tick pulses in the first
// cycle of every period. A new ratio that is loaded while running is held
// as pending and is switched in only at a period boundary, so the waveform
// never glitches.
//
// Parameters
//   CNT_W        width of ratio and phase counter (legal ratios 1..2^CNT_W-1)
//   DEFAULT_DIV  active ratio after reset (1..2^CNT_W-1)
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous, active-low reset
//   en         in   run enable (level)
//   load       in   strobe: capture div_ratio
//   div_ratio  in   requested ratio N, sampled only when load=1
//   clk_out    out  divided waveform, registered
//   tick       out  one-cycle pulse at each period start, registered
//   phase      out  current phase 0..N-1
//   ratio_err  out  sticky: a load of ratio 0 was attempted
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_ratio,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] phase,
    output logic             ratio_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

    state_t state_reg, state_next;

    logic [CNT_W-1:0] phase_reg,   phase_next;
    logic [CNT_W-1:0] active_reg,  active_next;
    logic [CNT_W-1:0] pending_reg, pending_next;
    logic             pending_valid_reg, pending_valid_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg,    tick_next;
    logic             ratio_err_reg, ratio_err_next;

    // A zero ratio is never accepted; it only raises the sticky error.
    logic             load_ok;
    logic             load_zero;
    logic [CNT_W-1:0] last_phase;
    logic             wrap;
    logic [CNT_W-1:0] phase_inc;
    logic [CNT_W-1:0] high_len;

    assign load_ok    = load && (div_ratio != '0);
    assign load_zero  = load && (div_ratio == '0);
    // active_reg is always >= 1, so N-1 cannot underflow.
    assign last_phase = active_reg - ONE;
    assign wrap       = (phase_reg == last_phase);
    assign phase_inc  = phase_reg + ONE;
    // ceil(N/2): number of high cycles in a period.
    assign high_len   = (active_reg >> 1) + {{(CNT_W-1){1'b0}}, active_reg[0]};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: en alone decides run vs. idle; there is no pause.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = en ? RUN : IDLE;
            RUN:     state_next = en ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Defaults are the idle output values; ratios hold.
        phase_next         = '0;
        tick_next          = 1'b0;
        clk_out_next       = 1'b0;
        active_next        = active_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        ratio_err_next     = ratio_err_reg | load_zero;

        case (state_reg)
            IDLE: begin
                // While idle a load takes effect at once, so a load on the
                // same edge as en rising governs the very first period.
                if (load_ok) begin
                    active_next = div_ratio;
                end
                if (en) begin
                    tick_next    = 1'b1;
                    clk_out_next = 1'b1;
                end
            end

            RUN: begin
                if (en) begin
                    if (wrap) begin
                        tick_next    = 1'b1;
                        clk_out_next = 1'b1;
                        if (pending_valid_reg) begin
                            active_next        = pending_reg;
                            pending_valid_next = 1'b0;
                        end
                    end else begin
                        phase_next   = phase_inc;
                        clk_out_next = (phase_inc < high_len);
                    end
                end
                // Written after the wrap handling so that a load on a wrap
                // edge becomes pending for the following wrap, while the
                // previously pending value is the one switched in now.
                if (load_ok) begin
                    pending_next       = div_ratio;
                    pending_valid_next = 1'b1;
                end
            end

            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg         <= '0;
            tick_reg          <= 1'b0;
            clk_out_reg       <= 1'b0;
            active_reg        <= DIV_INIT;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            ratio_err_reg     <= 1'b0;
        end else begin
            phase_reg         <= phase_next;
            tick_reg          <= tick_next;
            clk_out_reg       <= clk_out_next;
            active_reg        <= active_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            ratio_err_reg     <= ratio_err_next;
        end
    end

    assign clk_out   = clk_out_reg;
    assign tick      = tick_reg;
    assign phase     = phase_reg;
    assign ratio_err = ratio_err_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
//
// Self-checking bench for clk_div_prog. A behavioural model tracks
// "running / position within period / active N / pending N / error" with
// plain integers and derives the expected outputs arithmetically:
//   tick    = running && pos == 0
//   clk_out = running && pos < ceil(N/2)
//   phase   = running ? pos : 0
// Directed scenarios are followed by a randomized run; every cycle is
// compared and period lengths are measured explicitly.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [CNT_W-1:0] div_ratio = '0;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] phase;
    logic             ratio_err;

    clk_div_prog #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .div_ratio(div_ratio),
        .clk_out  (clk_out),
        .tick     (tick),
        .phase    (phase),
        .ratio_err(ratio_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_act  = DEFAULT_DIV;
    int m_pend = 0;      // 0 = nothing pending
    bit m_err  = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply the rules for one rising edge using the inputs in force.
    task automatic model_edge(input bit r, input bit e, input bit l, input int d);
        if (!r) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_act  = DEFAULT_DIV;
            m_pend = 0;
            m_err  = 1'b0;
            return;
        end
        if (l && d == 0) m_err = 1'b1;
        if (!m_run) begin
            if (l && d != 0) m_act = d;
            if (e) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            if (!e) begin
                m_run = 1'b0;
                m_pos = 0;
            end else if (m_pos == m_act - 1) begin
                m_pos = 0;
                if (m_pend != 0) begin
                    m_act  = m_pend;
                    m_pend = 0;
                end
            end else begin
                m_pos = m_pos + 1;
            end
            if (l && d != 0) m_pend = d;
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare on the falling edge.
    task automatic cycle(input bit r, input bit e, input bit l, input int d);
        rst_n     = r;
        en        = e;
        load      = l;
        div_ratio = CNT_W'(d);
        @(posedge clk);
        model_edge(r, e, l, d);
        @(negedge clk);
        check("tick",      int'(tick),      (m_run && m_pos == 0) ? 1 : 0);
        check("clk_out",   int'(clk_out),   (m_run && m_pos < (m_act + 1) / 2) ? 1 : 0);
        check("phase",     int'(phase),     m_run ? m_pos : 0);
        check("ratio_err", int'(ratio_err), int'(m_err));
        load = 1'b0;
    endtask

    // Run with en=1 until a tick is seen; n = cycles taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle(1, 1, 0, 0);
            n++;
        end while (!tick && n < 300);
        if (!tick) check("tick_timeout", 0, 1);
    endtask

    int n;
    int cnt;

    initial begin
        // Reset state
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("rst_phase", int'(phase), 0);

        // Default ratio 16: first tick 1 clock after en, 8 high / 8 low
        cycle(1, 1, 0, 0);
        check("first_tick", int'(tick), 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (clk_out) cnt++;
            if (i < 15) cycle(1, 1, 0, 0);
        end
        check("div16_high", cnt, 8);
        wait_tick(n);
        check("div16_wrap", n, 1);
        wait_tick(n);
        check("div16_period", n, 16);

        // Idle load 5, then run: high 3 / low 2
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 5);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, 0);
            if (clk_out) cnt++;
        end
        check("div5_high", cnt, 12);
        wait_tick(n);
        wait_tick(n);
        check("div5_period", n, 5);

        // N=4, load 6 at phase 1, load 10 at phase 2: last wins
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 4);
        cycle(1, 1, 0, 0);                 // phase 0
        cycle(1, 1, 0, 0);                 // phase 1
        cycle(1, 1, 1, 6);                 // phase 2
        cycle(1, 1, 1, 10);                // phase 3
        wait_tick(n);
        check("old_period_end", n, 1);
        wait_tick(n);
        check("last_load_wins", n, 10);

        // Load 0 while running at N=8
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 8);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 0);
        check("err_set", int'(ratio_err), 1);
        wait_tick(n);
        wait_tick(n);
        check("div8_kept", n, 8);
        cycle(1, 1, 1, 3);
        wait_tick(n);
        wait_tick(n);
        check("div3_period", n, 3);
        check("err_sticky", int'(ratio_err), 1);

        // N=1: tick and clk_out every cycle, cleared immediately on stop
        cycle(1, 0, 1, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
        check("n1_tick", int'(tick), 1);
        cycle(1, 0, 0, 0);
        check("n1_stop_clk", int'(clk_out), 0);

        // Reset mid-run at phase 7 of N=16 with a pending value
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 9);
        while (m_pos != 7) cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("rst_mid_err", int'(ratio_err), 0);
        cycle(1, 1, 0, 0);
        wait_tick(n);
        check("rst_clean_period", n, 16);
        wait_tick(n);
        check("pending_cleared", n, 16);

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            bit r, e, l;
            int d;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 19) == 0);
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            cycle(r, e, l, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
